mips_trace_buffer: RTL and testbench
====================================

MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, trace entries held; power of two, 4..256.
REQ-002 Parameter POST, default 4, samples captured after the trigger sample; 1 <= POST < DEPTH.
REQ-003 clk  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 arm  input  1  one-cycle start request, honoured only in IDLE.
REQ-006 trig_pc  input  32  PC value that fires the trigger; sampled each cycle.
REQ-007 sample_valid  input  1  core debug outputs valid this cycle.
REQ-008 pc_in / alu_in / mem_in  input  32 each  fed by core debug_pc_out, debug_alu_result, debug_d_mem_read_data.
REQ-009 rd_valid  output  1  readout entry present on rd_pc/rd_alu/rd_mem.
REQ-010 rd_ready  input  1  consumer accepts the entry.
REQ-011 rd_pc / rd_alu / rd_mem  output  32 each  current readout entry fields.
REQ-012 rd_last  output  1  current readout entry is the newest one.
REQ-013 state  output  2  IDLE=0, ARMED=1, POST=2, DUMP=3.
REQ-014 count  output  log2(DEPTH)+1  valid entries held.

Function
REQ-015 Storage shall be a DEPTH-entry circular array of 96-bit {pc,alu,mem}, write pointer wr_ptr wrapping DEPTH-1 -> 0.
REQ-016 IDLE: no writes; arm=1 shall clear count to 0, wr_ptr to 0 and enter ARMED next cycle.
REQ-017 ARMED: each cycle with sample_valid=1 shall write the inputs at wr_ptr, advance wr_ptr, increment count saturating at DEPTH (oldest entry overwritten when full).
REQ-018 ARMED with sample_valid=1 and pc_in==trig_pc: that sample shall be written (per REQ-017), post counter loaded with POST, go to POST.
REQ-019 Trigger compare shall be ignored when sample_valid=0.
REQ-020 POST: writes per REQ-017; each write decrements post counter; the write taking it to 0 shall move to DUMP next cycle.
REQ-021 sample_valid=0 cycles in POST shall stall the countdown without leaving POST.
REQ-022 DUMP entry: rd_ptr = (wr_ptr - count) mod DEPTH (oldest entry); remaining = count.
REQ-023 DUMP: rd_valid=1 while remaining>0; rd_* shall show entry at rd_ptr combinationally from the array.
REQ-024 Transfer occurs when rd_valid && rd_ready: rd_ptr advances with wrap, remaining and count decrement.
REQ-025 rd_valid with rd_ready=0 shall hold rd_* stable until accepted.
REQ-026 rd_last=1 iff rd_valid=1 and remaining==1.
REQ-027 Transfer of the rd_last entry shall return to IDLE next cycle; rd_valid=0 in IDLE, ARMED, POST.
REQ-028 No writes in DUMP regardless of sample_valid; arm outside IDLE shall be ignored.
REQ-029 Simultaneous arm and sample_valid in IDLE: sample not stored.

Reset
REQ-030 reset=0 shall asynchronously set state=IDLE, wr_ptr=0, rd_ptr=0, count=0, post counter=0, rd_valid=0, rd_last=0; array contents undefined, never read before written.
REQ-031 Reset asserted in any state, including mid-DUMP, shall abort the operation with no further transfers.
REQ-032 First arm is honoured on the first posedge after reset deassertion.

Verification
REQ-033 Reset, arm, feed pc_in=0,4,8,...; trig_pc=12, POST=4, rd_ready=1 -> 8 entries read, pc 0..28 in order, rd_last on pc=28, then state=0.
REQ-034 DEPTH=16, trig_pc=400, pcs 0,4,...,416 -> exactly 16 entries read, pc 356..416, count=16 at DUMP entry (wrap and overwrite).
REQ-035 Trigger pc=12 with sample_valid low on alternate cycles during POST -> still exactly 4 post-trigger entries, pcs contiguous.
REQ-036 In DUMP toggle rd_ready 1,0,0,1 -> rd_pc unchanged across stalled cycles, no entry duplicated or skipped.
REQ-037 Assert reset=0 mid-DUMP after 3 transfers, asynchronously between edges -> rd_valid=0, state=0, count=0 before next posedge.
REQ-038 arm pulsed in ARMED and DUMP -> no effect on count, pointers or state.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// Trace buffer for the MIPS core debug port.
// Continuously records {pc, alu, mem} samples into a circular array once armed,
// keeps POST more samples after the trigger PC is seen, then replays the held
// window oldest-first through a valid/ready readout port.
module mips_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int POST  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [31:0]              trig_pc,
  input  logic                     sample_valid,
  input  logic [31:0]              pc_in,
  input  logic [31:0]              alu_in,
  input  logic [31:0]              mem_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_alu,
  output logic [31:0]              rd_mem,
  output logic                     rd_last,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] POST_LD  = AW'(POST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   post_cnt;
  logic [AW:0]     count_q;
  logic [95:0]     mem_q [DEPTH];

  logic            wr_en;
  logic            xfer;
  logic [AW-1:0]   wr_ptr_nxt;
  logic [AW:0]     cnt_inc;
  logic [95:0]     rd_entry;

  // Capture happens only while recording; the trigger check never gates the write.
  assign wr_en      = sample_valid && ((state_q == S_ARMED) || (state_q == S_POST));
  assign wr_ptr_nxt = wr_ptr + PTR_ONE;
  // Count saturates at DEPTH: once full, each new sample overwrites the oldest.
  assign cnt_inc    = (count_q == FULL) ? count_q : (count_q + CNT_ONE);

  assign rd_valid = (state_q == S_DUMP) && (count_q != '0);
  assign rd_last  = rd_valid && (count_q == CNT_ONE);
  assign xfer     = rd_valid && rd_ready;
  assign rd_entry = mem_q[rd_ptr];
  assign rd_pc    = rd_entry[95:64];
  assign rd_alu   = rd_entry[63:32];
  assign rd_mem   = rd_entry[31:0];
  assign state    = state_q;
  assign count    = count_q;

  // Trace storage: data only, no reset; entries are never read before written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= {pc_in, alu_in, mem_in};
    end
  end

  // Capture/readout controller: pointers, fill count, post-trigger countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      post_cnt <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            count_q <= '0;
            wr_ptr  <= '0;
            state_q <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (sample_valid) begin
            wr_ptr  <= wr_ptr_nxt;
            count_q <= cnt_inc;
            if (pc_in == trig_pc) begin
              post_cnt <= POST_LD;
              state_q  <= S_POST;
            end
          end
        end
        S_POST: begin
          if (sample_valid) begin
            wr_ptr   <= wr_ptr_nxt;
            count_q  <= cnt_inc;
            post_cnt <= post_cnt - PTR_ONE;
            if (post_cnt == PTR_ONE) begin
              // Oldest held entry sits count places behind the write pointer.
              rd_ptr  <= wr_ptr_nxt - cnt_inc[AW-1:0];
              state_q <= S_DUMP;
            end
          end
        end
        S_DUMP: begin
          if (count_q == '0) begin
            state_q <= S_IDLE;
          end else if (xfer) begin
            rd_ptr  <= rd_ptr + PTR_ONE;
            count_q <= count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer (DEPTH=16, POST=4).
module tb_mips_trace_buffer;

  localparam int DEPTH = 16;
  localparam int POST  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] pc_in = '0, alu_in = '0, mem_in = '0;
  logic        rd_valid, rd_ready = 1'b0;
  logic [31:0] rd_pc, rd_alu, rd_mem;
  logic        rd_last;
  logic [1:0]  state;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
  } ent_t;

  ent_t exp_q[$];

  typedef struct {
    bit          arm;
    bit          sv;
    logic [31:0] pc;
    int          st;
    int          cnt;
  } vec_t;

  mips_trace_buffer #(.DEPTH(DEPTH), .POST(POST)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_pc(trig_pc),
    .sample_valid(sample_valid), .pc_in(pc_in), .alu_in(alu_in), .mem_in(mem_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_alu(rd_alu),
    .rd_mem(rd_mem), .rd_last(rd_last), .state(state), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Replay exp_q through the readout port; optionally abort with async reset.
  task automatic read_dump(input int rdy_mode, input bit arm_noise, input int abort_after);
    int idx = 0;
    int n = exp_q.size();
    int k = 0;
    for (int cyc = 0; cyc < n * 6 + 20 && idx < n; cyc++) begin
      if (abort_after > 0 && idx == abort_after) begin
        #2 reset = 1'b0;
        #1;
        check("abort_rd_valid", 32'(rd_valid), 0);
        check("abort_state", 32'(state), 0);
        check("abort_count", 32'(count), 0);
        rd_ready = 1'b0;
        arm = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      case (rdy_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (k % 4 == 0) || (k % 4 == 3);
        default: rd_ready = ($urandom_range(0, 2) != 0);
      endcase
      k++;
      arm = arm_noise ? ($urandom_range(0, 2) == 0) : 1'b0;
      check("rd_valid", 32'(rd_valid), 1);
      check("rd_pc", rd_pc, exp_q[idx].pc);
      check("rd_alu", rd_alu, exp_q[idx].alu);
      check("rd_mem", rd_mem, exp_q[idx].mem);
      check("rd_last", 32'(rd_last), 32'(idx == n - 1));
      check("dump_count", 32'(count), 32'(n - idx));
      step();
      if (rd_ready) idx++;
    end
    rd_ready = 1'b0;
    arm = 1'b0;
    if (idx < n) begin
      errors++;
      checks++;
      $display("FAIL dump_timeout read=%0d expected=%0d", idx, n);
    end
    check("end_state", 32'(state), 0);
    check("end_rd_valid", 32'(rd_valid), 0);
    check("end_count", 32'(count), 0);
  endtask

  // Arm, feed a PC stream, and predict the held window from the capture rules.
  task automatic run_trace(input logic [31:0] trig, input int gap_mode, input int rdy_mode,
                           input bit arm_noise, input int abort_after);
    ent_t q[$];
    bit   trig_seen = 0;
    bit   done = 0;
    int   post_left = 0;
    int   pc = 0;
    int   n;
    trig_pc = trig;
    arm = 1'b1;
    sample_valid = 1'b1;
    pc_in = trig;
    step();
    arm = 1'b0;
    check("arm_state", 32'(state), 1);
    check("arm_count", 32'(count), 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit v;
      v = 1'b1;
      if (gap_mode == 1 && trig_seen && (cyc % 2 == 1)) v = 1'b0;
      if (gap_mode == 2) v = ($urandom_range(0, 2) != 0);
      sample_valid = v;
      pc_in = v ? 32'(pc) : trig;
      alu_in = $urandom;
      mem_in = $urandom;
      arm = arm_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (v) begin
        q.push_back('{pc: pc_in, alu: alu_in, mem: mem_in});
        pc += 4;
        if (!trig_seen) begin
          if (pc_in == trig) begin
            trig_seen = 1;
            post_left = POST;
          end
        end else begin
          post_left--;
        end
      end
      step();
      if (trig_seen && post_left == 0) begin
        done = 1;
        break;
      end
      check("feed_state", 32'(state), trig_seen ? 2 : 1);
      check("feed_count", 32'(count), 32'(q.size() > DEPTH ? DEPTH : q.size()));
      check("feed_rd_valid", 32'(rd_valid), 0);
    end
    sample_valid = 1'b0;
    arm = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL capture_timeout trig=%0d state=%0d", trig, state);
      return;
    end
    n = (q.size() > DEPTH) ? DEPTH : q.size();
    check("dump_state", 32'(state), 3);
    check("dump_entry_count", 32'(count), 32'(n));
    exp_q.delete();
    for (int i = q.size() - n; i < q.size(); i++) exp_q.push_back(q[i]);
    read_dump(rdy_mode, arm_noise, abort_after);
  endtask

  initial begin
    vec_t vt[$];
    // Reset state while reset is held low
    #3;
    check("rst_state", 32'(state), 0);
    check("rst_count", 32'(count), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_last", 32'(rd_last), 0);
    step();
    @(negedge clk);
    reset = 1'b1;

    // Table: arm with a simultaneous sample, then pcs 0..28 with trigger at 12
    vt.push_back('{arm: 1, sv: 1, pc: 32'd99, st: 1, cnt: 0});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd0,  st: 1, cnt: 1});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd4,  st: 1, cnt: 2});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd8,  st: 1, cnt: 3});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd12, st: 2, cnt: 4});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd16, st: 2, cnt: 5});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd20, st: 2, cnt: 6});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd24, st: 2, cnt: 7});
    vt.push_back('{arm: 0, sv: 1, pc: 32'd28, st: 3, cnt: 8});
    trig_pc = 32'd12;
    exp_q.delete();
    for (int i = 0; i < vt.size(); i++) begin
      arm = vt[i].arm;
      sample_valid = vt[i].sv;
      pc_in = vt[i].pc;
      alu_in = vt[i].pc ^ 32'hA5A5_0000;
      mem_in = ~vt[i].pc;
      if (!vt[i].arm) exp_q.push_back('{pc: pc_in, alu: alu_in, mem: mem_in});
      step();
      check("tbl_state", 32'(state), 32'(vt[i].st));
      check("tbl_count", 32'(count), 32'(vt[i].cnt));
    end
    arm = 1'b0;
    sample_valid = 1'b0;
    read_dump(0, 0, 0);

    // Wrap and overwrite: 105 samples, only the newest 16 survive
    run_trace(32'd400, 0, 0, 0, 0);
    // Gapped post-trigger capture
    run_trace(32'd12, 1, 0, 0, 0);
    // Readout backpressure 1,0,0,1
    run_trace(32'd20, 0, 1, 0, 0);
    // Async reset after 3 transfers, then re-arm on the first edge
    run_trace(32'd40, 0, 0, 0, 3);
    // Arm pulses while busy must be ignored
    run_trace(32'd28, 0, 1, 1, 0);
    // Randomized trials
    for (int t = 0; t < 6; t++) begin
      run_trace(32'($urandom_range(0, 30) * 4), 2, 2, 1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
